// File: rtl/err_display_scan_if.sv
// Controller-to-display bundle for err_display_scan: error inputs in, active-low pins out.
// The master side is the error source and observer; the slave side is the display driver.
interface err_display_scan_if #(
    parameter int N_DIGITS = 4,
    parameter int CODE_W   = 2
);
    logic                En;
    logic [CODE_W-1:0]   Code;
    logic                Ack;
    logic [6:0]          SEG;
    logic                SEG_P;
    logic [N_DIGITS-1:0] AN;

    modport master (
        output En,
        output Code,
        output Ack,
        input  SEG,
        input  SEG_P,
        input  AN
    );

    modport slave (
        input  En,
        input  Code,
        input  Ack,
        output SEG,
        output SEG_P,
        output AN
    );
endinterface

// File: rtl/err_display_scan.sv
// Latches an error code and scans "E r r <code>" across N_DIGITS active-low 7-segment digits.
// Optional occurrence counter on digit 1 and the digit-0 decimal point: define ERR_COUNT_EN.
module err_display_scan #(
    parameter int N_DIGITS  = 4,
    parameter int CODE_W    = 2,
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 16
) (
    input  logic                clk,
    input  logic                rst,
    err_display_scan_if.slave   bus
);

    localparam int IDX_W  = $clog2(N_DIGITS);
    localparam int SCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BCNT_W = $clog2(BLINK_DIV);

    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCAN_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HOLD
    } state_t;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    state_t              state_q,    state_d;
    logic [CODE_W-1:0]   code_q,     code_d;
    logic [SCNT_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [BCNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                phase_q,    phase_d;
    logic [6:0]          seg_q,      seg_d;
    logic                seg_p_q,    seg_p_d;
    logic [N_DIGITS-1:0] an_q,       an_d;
`ifdef ERR_COUNT_EN
    logic [3:0]          err_cnt_q,  err_cnt_d;
`endif

    // Next-state for the mode FSM and the free-running scan/blink timebases.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        scan_cnt_d  = scan_cnt_q;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        case (state_q)
            S_IDLE: begin
                if (bus.En) begin
                    state_d = S_ACTIVE;
                    code_d  = bus.Code;
                end
            end
            S_ACTIVE: begin
                if (bus.En) begin
                    code_d = bus.Code;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.En) begin
                    state_d = S_ACTIVE;
                    code_d  = bus.Code;
                end else if (bus.Ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (scan_cnt_q == SCNT_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end

        if (blink_cnt_q == BCNT_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

`ifdef ERR_COUNT_EN
    // Count entries into ACTIVE (from IDLE or HOLD), saturating at 9; acknowledge clears.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == S_HOLD && state_d == S_IDLE) begin
            err_cnt_d = '0;
        end else if (state_q != S_ACTIVE && state_d == S_ACTIVE && err_cnt_q != 4'd9) begin
            err_cnt_d = err_cnt_q + 4'd1;
        end
    end
`endif

    // Output pins are a registered function of the current state and scan position.
    always_comb begin
        seg_d   = GLYPH_BLANK;
        seg_p_d = 1'b1;
        an_d    = '1;

        if (state_q != S_IDLE) begin
            an_d = ~(N_DIGITS'(1) << idx_q);

            if (idx_q == IDX_LAST) begin
                seg_d = GLYPH_E;
            end else if (idx_q == '0) begin
                seg_d = hex_glyph(4'(code_q));
            end else begin
                seg_d = GLYPH_R;
`ifdef ERR_COUNT_EN
                if (N_DIGITS >= 3 && idx_q == IDX_W'(1)) begin
                    seg_d = hex_glyph(err_cnt_q);
                end
`endif
            end

`ifdef ERR_COUNT_EN
            if (idx_q == '0 && err_cnt_q == 4'd9) begin
                seg_p_d = 1'b0;
            end
`endif

            if (state_q == S_HOLD && phase_q) begin
                seg_d = GLYPH_BLANK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            seg_q       <= GLYPH_BLANK;
            seg_p_q     <= 1'b1;
            an_q        <= '1;
`ifdef ERR_COUNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            seg_p_q     <= seg_p_d;
            an_q        <= an_d;
`ifdef ERR_COUNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign bus.SEG   = seg_q;
    assign bus.SEG_P = seg_p_q;
    assign bus.AN    = an_q;

endmodule

// File: tb/tb_err_display_scan.sv
// Directed plus random bench for err_display_scan, checked against a cycle-count based model.
// Works in both the default build and with ERR_COUNT_EN defined.
module tb_err_display_scan;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int SD = 4;
    localparam int BD = 16;

    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_R     = 7'b0101111;
    localparam logic [6:0] G_BLANK = 7'h7F;

    logic clk = 1'b0;
    logic rst;

    err_display_scan_if #(.N_DIGITS(N), .CODE_W(CW)) bus_if ();

    err_display_scan #(
        .N_DIGITS (N),
        .CODE_W   (CW),
        .SCAN_DIV (SD),
        .BLINK_DIV(BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode (0 idle, 1 active, 2 hold), latched code, occurrence count,
    // and edges since reset, from which scan digit and blink phase follow arithmetically.
    int m_state = 0;
    int m_code  = 0;
    int m_cnt   = 0;
    int m_c     = 0;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic en, input int code, input logic ack);
        logic [6:0]   es;
        logic         esp;
        logic [N-1:0] ean;
        int           idx;
        int           ph;

        rst         = r;
        bus_if.En   = en;
        bus_if.Code = CW'(code);
        bus_if.Ack  = ack;

        idx = (m_c / SD) % N;
        ph  = (m_c / BD) % 2;
        es  = G_BLANK;
        esp = 1'b1;
        ean = '1;
        if (!r && m_state != 0) begin
            ean[idx] = 1'b0;
            if (idx == N - 1)      es = G_E;
            else if (idx == 0)     es = glyph[m_code];
            else                   es = G_R;
`ifdef ERR_COUNT_EN
            if (N >= 3 && idx == 1) es = glyph[m_cnt];
            if (idx == 0 && m_cnt == 9) esp = 1'b0;
`endif
            if (m_state == 2 && ph == 1) es = G_BLANK;
        end

        if (r) begin
            m_state = 0;
            m_code  = 0;
            m_cnt   = 0;
            m_c     = 0;
        end else begin
            if (en) m_code = code % (1 << CW);
            case (m_state)
                0: if (en) begin m_state = 1; if (m_cnt < 9) m_cnt++; end
                1: if (!en) m_state = 2;
                default: begin
                    if (en) begin m_state = 1; if (m_cnt < 9) m_cnt++; end
                    else if (ack) begin m_state = 0; m_cnt = 0; end
                end
            endcase
            m_c++;
        end

        @(posedge clk);
        #1;
        check("SEG",   32'(bus_if.SEG),   32'(es));
        check("AN",    32'(bus_if.AN),    32'(ean));
        check("SEG_P", 32'(bus_if.SEG_P), 32'(esp));
    endtask

    initial begin
        logic r, en, ack;
        int   code;

        rst         = 1'b1;
        bus_if.En   = 1'b0;
        bus_if.Code = '0;
        bus_if.Ack  = 1'b0;

        // Reset held with an error pending, then basic steady display of code 2.
        repeat (3) step(1'b1, 1'b1, 2, 1'b0);
        check("RST_SEG_LIT", 32'(bus_if.SEG), 32'h7F);
        check("RST_AN_LIT",  32'(bus_if.AN),  32'hF);
        repeat (20) step(1'b0, 1'b1, 2, 1'b0);

        // Ack is ignored while the error is still present.
        repeat (6) step(1'b0, 1'b1, 2, 1'b1);

        // Latch code 3 then drop En: blinking HOLD across several blink periods.
        step(1'b0, 1'b1, 3, 1'b0);
        repeat (70) step(1'b0, 1'b0, 3, 1'b0);

        // Ack in HOLD returns to IDLE.
        step(1'b0, 1'b0, 3, 1'b1);
        repeat (6) step(1'b0, 1'b0, 0, 1'b0);

        // En and Ack together in HOLD: En wins.
        step(1'b0, 1'b1, 1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1, 1'b0);
        step(1'b0, 1'b1, 2, 1'b1);
        repeat (10) step(1'b0, 1'b1, 2, 1'b0);

        // Live code update while En stays high.
        repeat (8) step(1'b0, 1'b1, 1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 3, 1'b0);

        // Reset mid-operation with En and Ack asserted.
        step(1'b1, 1'b1, 3, 1'b1);
        repeat (4) step(1'b0, 1'b1, 2, 1'b0);

        // Ten occurrences, each followed by HOLD, then observe and acknowledge.
        for (int i = 0; i < 10; i++) begin
            repeat (2) step(1'b0, 1'b1, i % 4, 1'b0);
            repeat (2) step(1'b0, 1'b0, i % 4, 1'b0);
        end
        repeat (40) step(1'b0, 1'b0, 1, 1'b0);
        step(1'b0, 1'b0, 1, 1'b1);
        repeat (8) step(1'b0, 1'b1, 1, 1'b0);

        // Random traffic with sticky En so HOLD periods last long enough to blink.
        en = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 9) == 0) en = ~en;
            code = int'($urandom_range(0, (1 << CW) - 1));
            ack  = ($urandom_range(0, 11) == 0);
            step(r, en, code, ack);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
